// File: rtl/decode_hazard_ctrl.sv
// Decode-stage hazard controller: load-use stall, branch flush, and a
// three-stage EX/MEM/WB destination tag pipeline driving RF write enable.
module decode_hazard_ctrl #(
    parameter int unsigned FLUSH_LEN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ir_valid,
    input  logic [31:0] ir_in,
    input  logic        ex_stall,
    input  logic        br_taken,
    output logic        RegA_LATCH_EN,
    output logic        RegB_LATCH_EN,
    output logic        RegIMM_LATCH_EN,
    output logic        RF_WE,
    output logic        fetch_stall,
    output logic        dec_flush,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       is_load;
    } tag_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] CNT_INIT = 3'(FLUSH_LEN - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    tag_t       ex_q, ex_d;
    tag_t       mem_q, mem_d;
    tag_t       wb_q, wb_d;

    logic [6:0] opcode;
    logic [4:0] rs1, rs2, rd;
    logic       uses_rs1, uses_rs2, writes_rd, is_load;
    logic       hazard;
    logic       latch_en;
    logic       fetch_stall_raw;
    logic       unused_ir_bits;

    assign opcode = ir_in[6:0];
    assign rd     = ir_in[11:7];
    assign rs1    = ir_in[19:15];
    assign rs2    = ir_in[24:20];

    assign unused_ir_bits = ^{ir_in[31:25], ir_in[14:12]};

    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        case (opcode)
            OP_LOAD: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                is_load   = 1'b1;
            end
            OP_IMM, OP_JALR: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
            end
            OP_REG: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_JAL, OP_LUI, OP_AUIPC: begin
                writes_rd = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Only a load still in EX stalls; MEM/WB producers are forwarded.
    assign hazard = ex_q.valid & ex_q.is_load & (ex_q.rd != 5'd0)
                  & ((uses_rs1 & (rs1 == ex_q.rd))
                   | (uses_rs2 & (rs2 == ex_q.rd)));

    assign latch_en = (state_q == RUN) & ir_valid & ~ex_stall
                    & ~hazard & ~br_taken;

    assign fetch_stall_raw = ~br_taken
                           & (ex_stall
                            | (state_q == STALL)
                            | ((state_q == RUN) & hazard));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (br_taken) begin
            state_d = FLUSH;
            cnt_d   = CNT_INIT;
        end else if (!ex_stall) begin
            unique case (state_q)
                RUN: begin
                    if (hazard) state_d = STALL;
                end
                STALL: begin
                    state_d = RUN;
                end
                FLUSH: begin
                    if (cnt_q == 3'd0) state_d = RUN;
                    else cnt_d = cnt_q - 3'd1;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // A real tag enters EX exactly when decode latches its operands.
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!ex_stall) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            ex_d  = '0;
            if (latch_en) begin
                ex_d.valid   = 1'b1;
                ex_d.rd      = rd;
                ex_d.we      = writes_rd & (rd != 5'd0);
                ex_d.is_load = is_load;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
        end
    end

    assign RegA_LATCH_EN   = ~rst & latch_en;
    assign RegB_LATCH_EN   = ~rst & latch_en;
    assign RegIMM_LATCH_EN = ~rst & latch_en;
    assign RF_WE           = ~rst & wb_q.valid & wb_q.we & ~ex_stall;
    assign fetch_stall     = ~rst & fetch_stall_raw;
    assign dec_flush       = ~rst & (br_taken | (state_q == FLUSH));
    assign state           = rst ? 2'd0 : state_q;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Scoreboard bench for decode_hazard_ctrl: directed scenarios followed by
// randomized traffic, checked against an instruction-level reference model.
module tb_decode_hazard_ctrl;

    localparam int FL = 2;

    logic        clk;
    logic        rst;
    logic        ir_valid;
    logic [31:0] ir_in;
    logic        ex_stall;
    logic        br_taken;
    logic        RegA_LATCH_EN;
    logic        RegB_LATCH_EN;
    logic        RegIMM_LATCH_EN;
    logic        RF_WE;
    logic        fetch_stall;
    logic        dec_flush;
    logic [1:0]  state;

    decode_hazard_ctrl #(.FLUSH_LEN(FL)) dut (
        .clk             (clk),
        .rst             (rst),
        .ir_valid        (ir_valid),
        .ir_in           (ir_in),
        .ex_stall        (ex_stall),
        .br_taken        (br_taken),
        .RegA_LATCH_EN   (RegA_LATCH_EN),
        .RegB_LATCH_EN   (RegB_LATCH_EN),
        .RegIMM_LATCH_EN (RegIMM_LATCH_EN),
        .RF_WE           (RF_WE),
        .fetch_stall     (fetch_stall),
        .dec_flush       (dec_flush),
        .state           (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector: {enA, enB, enIMM, RF_WE, fetch_stall, dec_flush, state}
    typedef struct {
        string      nm;
        logic [7:0] val;
    } sb_t;

    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       w;
        bit       ld;
    } mtag_t;

    sb_t   sbq[$];
    mtag_t pipe[$];
    int    mst;
    int    mleft;
    int    n_checks;
    int    n_fail;

    localparam logic [31:0] LW_X5   = 32'h0000A283;
    localparam logic [31:0] ADD_DEP = 32'h00228333;
    localparam logic [31:0] ADD_IND = 32'h00218333;
    localparam logic [31:0] NOP_I   = 32'h00000013;

    function automatic void dec(input logic [31:0] i, output bit u1,
                                output bit u2, output bit wr,
                                output bit ld);
        logic [6:0] op;
        op = i[6:0];
        u1 = 0; u2 = 0; wr = 0; ld = 0;
        case (op)
            7'b0000011: begin u1 = 1; wr = 1; ld = 1; end
            7'b0010011: begin u1 = 1; wr = 1; end
            7'b0110011: begin u1 = 1; u2 = 1; wr = 1; end
            7'b0100011: begin u1 = 1; u2 = 1; end
            7'b1100011: begin u1 = 1; u2 = 1; end
            7'b1101111: begin wr = 1; end
            7'b1100111: begin u1 = 1; wr = 1; end
            7'b0110111: begin wr = 1; end
            7'b0010111: begin wr = 1; end
            default: begin end
        endcase
        if (i[11:7] == 5'd0) wr = 0;
    endfunction

    function automatic void model_reset();
        mtag_t z;
        z = '{v: 0, rd: 0, w: 0, ld: 0};
        pipe.delete();
        repeat (3) pipe.push_back(z);
        mst   = 0;
        mleft = 0;
    endfunction

    function automatic void model_step(input bit r, input bit v,
                                       input logic [31:0] ins,
                                       input bit s, input bit b,
                                       input string nm);
        sb_t   e;
        mtag_t t;
        bit    u1, u2, wr, ld, haz, en, fs, df, we;
        e.nm = nm;
        if (r) begin
            e.val = 8'h00;
            sbq.push_back(e);
            model_reset();
            return;
        end
        dec(ins, u1, u2, wr, ld);
        haz = pipe[0].v && pipe[0].ld && (pipe[0].rd != 0)
           && ((u1 && ins[19:15] == pipe[0].rd)
            || (u2 && ins[24:20] == pipe[0].rd));
        en = (mst == 0) && v && !s && !haz && !b;
        fs = !b && (s || mst == 1 || (mst == 0 && haz));
        df = b || (mst == 2);
        we = pipe[2].v && pipe[2].w && !s;
        e.val = {en, en, en, we, fs, df, 2'(mst)};
        sbq.push_back(e);
        if (b) begin
            mst   = 2;
            mleft = FL - 1;
        end else if (!s) begin
            if (mst == 0 && haz) mst = 1;
            else if (mst == 1) mst = 0;
            else if (mst == 2) begin
                if (mleft == 0) mst = 0;
                else mleft--;
            end
        end
        if (!s) begin
            t.v  = en;
            t.rd = ins[11:7];
            t.w  = en && wr;
            t.ld = en && ld;
            pipe.push_front(t);
            void'(pipe.pop_back());
        end
    endfunction

    task automatic cyc(input bit r, input bit v, input logic [31:0] ins,
                       input bit s, input bit b, input string nm);
        @(posedge clk);
        #1;
        rst      = r;
        ir_valid = v;
        ir_in    = ins;
        ex_stall = s;
        br_taken = b;
        model_step(r, v, ins, s, b, nm);
    endtask

    always @(negedge clk) begin
        sb_t        e;
        logic [7:0] act;
        if (sbq.size() > 0) begin
            e   = sbq.pop_front();
            act = {RegA_LATCH_EN, RegB_LATCH_EN, RegIMM_LATCH_EN, RF_WE,
                   fetch_stall, dec_flush, state};
            n_checks++;
            if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s @%0t: got %b expected %b",
                         e.nm, $time, act, e.val);
            end
        end
    end

    logic [6:0] ops [11];

    function automatic logic [31:0] rand_ins();
        logic [31:0] i;
        i        = $urandom;
        i[6:0]   = ops[$urandom_range(0, 10)];
        i[11:7]  = 5'($urandom_range(0, 3));
        i[19:15] = 5'($urandom_range(0, 3));
        i[24:20] = 5'($urandom_range(0, 3));
        return i;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        ir_valid = 1'b0;
        ir_in    = '0;
        ex_stall = 1'b0;
        br_taken = 1'b0;
        ops = '{7'b0000011, 7'b0010011, 7'b0110011, 7'b0100011,
                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                7'b0010111, 7'b1111111, 7'b0000011};
        model_reset();

        cyc(1, 0, NOP_I, 0, 0, "reset");
        cyc(1, 1, LW_X5, 0, 0, "reset");

        cyc(0, 1, LW_X5,   0, 0, "lduse_lw");
        cyc(0, 1, ADD_DEP, 0, 0, "lduse_detect");
        cyc(0, 1, ADD_DEP, 0, 0, "lduse_stall");
        cyc(0, 1, ADD_DEP, 0, 0, "lduse_latch");
        repeat (4) cyc(0, 0, NOP_I, 0, 0, "lduse_drain");

        cyc(0, 1, LW_X5,   0, 0, "indep_lw");
        cyc(0, 1, ADD_IND, 0, 0, "indep_add");
        repeat (4) cyc(0, 0, NOP_I, 0, 0, "indep_drain");

        cyc(0, 1, ADD_IND, 0, 0, "redir_pre");
        cyc(0, 1, ADD_IND, 0, 1, "redir_N");
        cyc(0, 1, ADD_IND, 0, 0, "redir_N1");
        cyc(0, 1, ADD_IND, 0, 0, "redir_N2");
        cyc(0, 1, ADD_IND, 0, 0, "redir_N3");
        repeat (3) cyc(0, 0, NOP_I, 0, 0, "redir_drain");

        cyc(0, 1, LW_X5,   0, 0, "brstall_lw");
        cyc(0, 1, ADD_DEP, 0, 1, "brstall_br");
        cyc(0, 1, ADD_DEP, 0, 0, "brstall_flush");
        repeat (4) cyc(0, 0, NOP_I, 0, 0, "brstall_drain");

        cyc(0, 1, ADD_IND, 0, 0, "xs_pre");
        cyc(0, 1, ADD_IND, 0, 1, "xs_br");
        repeat (3) cyc(0, 1, ADD_IND, 1, 0, "xs_frozen");
        repeat (3) cyc(0, 1, ADD_IND, 0, 0, "xs_resume");

        cyc(0, 1, ADD_IND, 0, 1, "rstfl_br");
        cyc(0, 1, ADD_IND, 0, 0, "rstfl_cnt1");
        cyc(1, 1, ADD_IND, 0, 0, "rstfl_async");
        cyc(0, 1, ADD_IND, 0, 0, "rstfl_after");
        cyc(0, 1, ADD_IND, 0, 0, "rstfl_after");

        for (int k = 0; k < 3000; k++) begin
            cyc(($urandom_range(0, 149) == 0),
                ($urandom_range(0, 4) != 0),
                rand_ins(),
                ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 11) == 0),
                "random");
        end

        cyc(0, 0, NOP_I, 0, 0, "tail");
        @(posedge clk);
        @(posedge clk);
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_hazard_ctrl.md
DECODE_HAZARD_CTRL -- requirements
Module: decode_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst as in the rest of the codebase.
REQ-002 Parameter FLUSH_LEN SHALL default to 2 and set the number of bubble cycles after a redirect; legal range 1..7.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 ir_valid  in  1  IR_IN in decode holds a real instruction.
REQ-006 ir_in  in  32  RV32I instruction currently in decode.
REQ-007 ex_stall  in  1  downstream (EX/MEM) cannot accept; freeze.
REQ-008 br_taken  in  1  EX redirect (taken branch/jump), single-cycle pulse.
REQ-009 RegA_LATCH_EN  out  1  enable for the decode-stage RS1 output register.
REQ-010 RegB_LATCH_EN  out  1  enable for the decode-stage RS2 output register.
REQ-011 RegIMM_LATCH_EN  out  1  enable for the decode-stage immediate register.
REQ-012 RF_WE  out  1  register-file write enable for the WB-stage instruction.
REQ-013 fetch_stall  out  1  hold PC and the fetch/decode IR.
REQ-014 dec_flush  out  1  squash the fetch/decode IR (insert NOP).
REQ-015 state  out  2  FSM state: 0 RUN, 1 STALL, 2 FLUSH.

Function
REQ-016 Opcode decode, with opcode = ir_in[6:0]:
- LOAD 0000011: rs1, rd, is_load.
- OP-IMM 0010011: rs1, rd.
- OP 0110011: rs1, rs2, rd.
- STORE 0100011: rs1, rs2.
- BRANCH 1100011: rs1, rs2.
- JAL 1101111: rd.
- JALR 1100111: rs1, rd.
- LUI 0110111 and AUIPC 0010111: rd.
- Any other opcode: no reads and no writes (NOP).
REQ-017 A write to rd=0 SHALL be treated as no write.
REQ-018 The block SHALL keep a tag pipeline of three stages: EX, MEM and WB. Each stage holds {valid, rd[4:0], we, is_load}.
REQ-019 The tag pipeline SHALL advance each cycle that ex_stall=0. A bubble (valid=0) SHALL enter EX when:
- ir_valid=0, or
- a load-use hazard is detected, or
- the state is FLUSH, or
- br_taken=1.
REQ-020 The tag pipeline SHALL hold all stages while ex_stall=1.
REQ-021 Load-use hazard = EX.valid & EX.is_load & EX.rd!=0 & ((uses_rs1 & rs1==EX.rd) | (uses_rs2 & rs2==EX.rd)), where rs1 = ir_in[19:15] and rs2 = ir_in[24:20]. Hazards against MEM and WB are covered by forwarding and SHALL NOT stall.
REQ-022 RF_WE SHALL equal WB.valid & WB.we & ~ex_stall (combinational).
REQ-023 RUN behaviour:
- If there is a hazard and ex_stall=0: fetch_stall=1 and the next state is STALL.
- Otherwise the state stays RUN.
REQ-024 STALL SHALL last exactly one cycle, with fetch_stall=1 and all latch enables 0, then return to RUN.
REQ-025 A br_taken in any state SHALL have top priority:
- dec_flush=1 in the same cycle.
- Next state is FLUSH.
- The bubble counter is loaded with FLUSH_LEN-1.
REQ-026 FLUSH behaviour:
- dec_flush=1 and latch enables 0 each cycle.
- The counter decrements each cycle; when it reaches 0 the next state is RUN.
- A new br_taken reloads the counter.
REQ-027 Latch enables RegA/RegB/RegIMM SHALL be 1 only when all hold: state=RUN, ir_valid=1, ex_stall=0, no hazard, br_taken=0.
REQ-028 While ex_stall=1 and br_taken=0:
- fetch_stall=1.
- Latch enables 0.
- State and counter hold.
REQ-029 Priority order SHALL be br_taken > ex_stall > load-use hazard.

Reset
REQ-030 On rst=1 the block SHALL immediately (asynchronously) clear all tag valids and set state=RUN and counter=0.
REQ-031 During reset RF_WE, fetch_stall, dec_flush and all latch enables SHALL be 0.
REQ-032 Reset asserted mid-STALL or mid-FLUSH SHALL abort that state. The first cycle after deassertion SHALL be in RUN.

Verification
REQ-033 Load-use stall: lw x5,0(x1) (0x0000A283) followed by add x6,x5,x2 (0x00228333).
- Expect one cycle with fetch_stall=1, state=1 and latch enables 0.
- add latches one cycle later.
- RF_WE for x5 asserts 3 cycles after the lw latches.
REQ-034 Independent op: lw x5 followed by add x6,x3,x2 (0x00218333). Expect no stall and enables 1 in consecutive cycles.
REQ-035 Redirect with FLUSH_LEN=2: pulse br_taken at cycle N.
- dec_flush=1 in cycles N, N+1 and N+2.
- state=2 in N+1 and N+2, and 0 in N+3.
- No RF_WE from bubbles.
REQ-036 Redirect during STALL: assert br_taken in the same cycle a load-use hazard is detected. Expect state=2 (not 1) the next cycle.
REQ-037 ex_stall=1 held for 3 cycles during FLUSH. Expect state and counter frozen, RF_WE=0, and FLUSH resuming with its remaining count.
REQ-038 Reset mid-FLUSH: assert rst for one cycle at counter=1. Expect all outputs 0 asynchronously, then state=0 after release.
